// File: rtl/peak_meter_pkg.sv
// Shared types and constants for the peak-hold meter.
package peak_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  localparam int BAR_LEDS = 8;

  // Thermometer code: bit i is lit when level exceeds i.
  function automatic logic [BAR_LEDS-1:0] thermo(input logic [3:0] level);
    logic [BAR_LEDS-1:0] t;
    t = '0;
    for (int i = 0; i < BAR_LEDS; i++) begin
      t[i] = (level > 4'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/peak_meter_abs_mag.sv
// Signed-to-magnitude conversion; the most-negative code maps to 2^(WIDTH-1)
// without overflow because the result is read as unsigned.
module abs_mag #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] smpl,
  output logic [WIDTH-1:0] mag
);

  always_comb begin
    mag = smpl;
    if (smpl[WIDTH-1]) begin
      mag = ~smpl + WIDTH'(1);
    end
  end

endmodule

// File: rtl/peak_meter.sv
// Peak-hold meter: tracks |smpl|, holds for HOLD valid samples, then decays.
// Optional sticky full-scale flag enabled by defining CLIP_DETECT_EN.
//
// state    | meaning
// ST_IDLE  | peak is zero, waiting for a nonzero sample
// ST_HOLD  | peak held, hold_cnt counts valid samples below peak
// ST_DECAY | peak reduced by DECAY_STEP every DECAY_PER valid samples
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter int              HOLD       = 1024,
  parameter int              DECAY_PER  = 64,
  parameter logic [WIDTH-1:0] DECAY_STEP = WIDTH'('h0100)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    smpl,
  input  logic                vld,
  input  logic                clr,
  output logic [WIDTH-1:0]    peak,
  output logic [BAR_LEDS-1:0] bar,
  output logic                new_pk,
  output logic                clip
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int DW = $clog2(DECAY_PER + 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD - 1);
  localparam logic [DW-1:0] DEC_TC  = DW'(DECAY_PER - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [DW-1:0]    dec_cnt;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] decayed;
  logic             take_new;

  abs_mag #(.WIDTH(WIDTH)) u_abs_mag (
    .smpl (smpl),
    .mag  (mag)
  );

  // Saturating subtract: the peak never wraps below zero.
  always_comb begin
    decayed = '0;
    if (peak > DECAY_STEP) begin
      decayed = peak - DECAY_STEP;
    end
  end

  always_comb begin
    take_new = (mag >= peak) && (mag != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      peak     <= '0;
      hold_cnt <= '0;
      dec_cnt  <= '0;
      new_pk   <= 1'b0;
    end else begin
      new_pk <= 1'b0;
      if (clr) begin
        state    <= ST_IDLE;
        peak     <= '0;
        hold_cnt <= '0;
        dec_cnt  <= '0;
      end else if (vld) begin
        if (take_new) begin
          peak     <= mag;
          hold_cnt <= '0;
          dec_cnt  <= '0;
          state    <= ST_HOLD;
          new_pk   <= (mag > peak);
        end else if (mag < peak) begin
          case (state)
            ST_HOLD: begin
              if (hold_cnt == HOLD_TC) begin
                state    <= ST_DECAY;
                hold_cnt <= '0;
                dec_cnt  <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            ST_DECAY: begin
              if (dec_cnt == DEC_TC) begin
                peak    <= decayed;
                dec_cnt <= '0;
                if (decayed == '0) begin
                  state <= ST_IDLE;
                end
              end else begin
                dec_cnt <= dec_cnt + 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    bar = thermo(peak[WIDTH-1:WIDTH-4]);
  end

`ifdef CLIP_DETECT_EN
  localparam logic [WIDTH-1:0] FS_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] FS_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic clip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_q <= 1'b0;
    end else if (clr) begin
      clip_q <= 1'b0;
    end else if (vld && ((smpl == FS_POS) || (smpl == FS_NEG))) begin
      clip_q <= 1'b1;
    end
  end

  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_peak_meter.sv
// Directed vector bench for peak_meter (WIDTH=16, HOLD=4, DECAY_PER=2, STEP=0x1000).
module tb_peak_meter;
  import peak_meter_pkg::*;

`ifdef CLIP_DETECT_EN
  localparam logic CLIP_ON = 1'b1;
`else
  localparam logic CLIP_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] smpl;
  logic        vld;
  logic        clr;
  logic [15:0] peak;
  logic [7:0]  bar;
  logic        new_pk;
  logic        clip;

  int checks   = 0;
  int failures = 0;

  peak_meter #(
    .WIDTH      (16),
    .HOLD       (4),
    .DECAY_PER  (2),
    .DECAY_STEP (16'h1000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .smpl   (smpl),
    .vld    (vld),
    .clr    (clr),
    .peak   (peak),
    .bar    (bar),
    .new_pk (new_pk),
    .clip   (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [15:0] smpl;
    logic [15:0] peak;
    logic [7:0]  bar;
    logic        npk;
    logic        clip;
    state_t      st;
    int          hold;  // -1: not checked
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic v, input logic [15:0] s,
                              input logic [15:0] p, input logic [7:0] b, input logic n,
                              input logic cl, input state_t st, input int h);
    vec_t x;
    x.clr = c; x.vld = v; x.smpl = s; x.peak = p; x.bar = b;
    x.npk = n; x.clip = cl & CLIP_ON; x.st = st; x.hold = h;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; clr = 1'b0; smpl = '0;

    //  clr vld smpl      peak      bar    npk clip state     hold
    add(0, 1, 16'hC000, 16'h4000, 8'h0F, 1, 0, ST_HOLD,  0);
    add(0, 0, 16'hC000, 16'h4000, 8'h0F, 0, 0, ST_HOLD,  0);
    add(0, 1, 16'h0000, 16'h4000, 8'h0F, 0, 0, ST_HOLD,  1);
    add(0, 1, 16'h0000, 16'h4000, 8'h0F, 0, 0, ST_HOLD,  2);
    add(0, 1, 16'h0000, 16'h4000, 8'h0F, 0, 0, ST_HOLD,  3);
    add(0, 1, 16'h0000, 16'h4000, 8'h0F, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h4000, 8'h0F, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_DECAY, -1);
    add(0, 0, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h2000, 8'h03, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h2000, 8'h03, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h1000, 8'h01, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h1000, 8'h01, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h0000, 8'h00, 0, 0, ST_IDLE,  -1);
    add(0, 1, 16'h0000, 16'h0000, 8'h00, 0, 0, ST_IDLE,  -1);
    // re-arm and reach DECAY at 0x3000, then an equal sample returns to HOLD
    add(0, 1, 16'h3000, 16'h3000, 8'h07, 1, 0, ST_HOLD,  0);
    add(0, 1, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_HOLD,  1);
    add(0, 1, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_HOLD,  2);
    add(0, 1, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_HOLD,  3);
    add(0, 1, 16'h0000, 16'h3000, 8'h07, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h3000, 16'h3000, 8'h07, 0, 0, ST_HOLD,  0);
    add(0, 1, 16'h2000, 16'h3000, 8'h07, 0, 0, ST_HOLD,  1);
    add(0, 1, 16'hCFFF, 16'h3001, 8'h07, 1, 0, ST_HOLD,  0);
    add(0, 1, 16'h3002, 16'h3002, 8'h07, 1, 0, ST_HOLD,  0);
    add(0, 1, 16'h8000, 16'h8000, 8'hFF, 1, 1, ST_HOLD,  0);
    add(0, 1, 16'h0010, 16'h8000, 8'hFF, 0, 1, ST_HOLD,  1);
    add(0, 1, 16'hFFF0, 16'h8000, 8'hFF, 0, 1, ST_HOLD,  2);
    add(1, 1, 16'h7FFF, 16'h0000, 8'h00, 0, 0, ST_IDLE,  0);
    add(0, 1, 16'h0000, 16'h0000, 8'h00, 0, 0, ST_IDLE,  0);
    add(0, 1, 16'h7FFF, 16'h7FFF, 8'h7F, 1, 1, ST_HOLD,  0);
    add(1, 0, 16'h0000, 16'h0000, 8'h00, 0, 0, ST_IDLE,  0);
    // decay from below one step saturates to zero
    add(0, 1, 16'h0800, 16'h0800, 8'h00, 1, 0, ST_HOLD,  0);
    add(0, 1, 16'h0000, 16'h0800, 8'h00, 0, 0, ST_HOLD,  1);
    add(0, 1, 16'h0000, 16'h0800, 8'h00, 0, 0, ST_HOLD,  2);
    add(0, 1, 16'h0000, 16'h0800, 8'h00, 0, 0, ST_HOLD,  3);
    add(0, 1, 16'h0000, 16'h0800, 8'h00, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h0800, 8'h00, 0, 0, ST_DECAY, -1);
    add(0, 1, 16'h0000, 16'h0000, 8'h00, 0, 0, ST_IDLE,  -1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_peak",   0, peak,   16'h0000);
    chk("rst_bar",    0, bar,    8'h00);
    chk("rst_new_pk", 0, new_pk, 0);
    chk("rst_clip",   0, clip,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_peak", 0, peak, 16'h0000);
    chk("idle_state", 0, int'(dut.state), int'(ST_IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clr  = vecs[i].clr;
      vld  = vecs[i].vld;
      smpl = vecs[i].smpl;
      @(posedge clk);
      #1;
      chk("peak",   i + 1, peak,   vecs[i].peak);
      chk("bar",    i + 1, bar,    vecs[i].bar);
      chk("new_pk", i + 1, new_pk, vecs[i].npk);
      chk("clip",   i + 1, clip,   vecs[i].clip);
      chk("state",  i + 1, int'(dut.state), int'(vecs[i].st));
      if (vecs[i].hold >= 0) begin
        chk("hold_cnt", i + 1, int'(dut.hold_cnt), vecs[i].hold);
      end
    end

    // async reset while new_pk is high and mid-hold
    @(negedge clk);
    clr = 1'b0; vld = 1'b1; smpl = 16'h8000;
    @(posedge clk);
    #1;
    chk("pre_rst_new_pk", 100, new_pk, 1);
    chk("pre_rst_clip",   100, clip,   CLIP_ON);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_peak",   101, peak,   16'h0000);
    chk("async_bar",    101, bar,    8'h00);
    chk("async_new_pk", 101, new_pk, 0);
    chk("async_clip",   101, clip,   0);
    chk("async_state",  101, int'(dut.state), int'(ST_IDLE));

    // async reset mid-decay: no partial step survives
    @(negedge clk);
    rst_n = 1'b1; smpl = 16'h5000;
    @(posedge clk);
    @(negedge clk);
    smpl = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst2_state", 102, int'(dut.state), int'(ST_DECAY));
    chk("pre_rst2_peak",  102, peak, 16'h5000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async2_peak", 103, peak, 16'h0000);
    chk("async2_dec",  103, int'(dut.dec_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_peak", 104, peak, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_meter.md
# peak_meter

Parametrised audio peak-hold meter with magnitude compare, hold counter and linear decay. Takes signed sample stream, tracks absolute peak, holds it for a programmable number of samples, then decays it in fixed steps; drives an 8-segment LED bar graph and a one-cycle new-peak strobe. Sits on the sample path after the ADC/filter stage, feeding board LEDs and the display logic. Generalises the earlier fixed 15-bit magnitude comparator and 4-bit enable incrementer into one clocked block.

## Interface
- WIDTH, 16, signed sample width (>= 5)
- HOLD, 1024, valid samples a peak is held before decay starts (>= 1)
- DECAY_PER, 64, valid samples between decay steps (>= 1)
- DECAY_STEP, 16'h0100, amount subtracted from peak per decay step (WIDTH bits, unsigned)
- clk  in  1  system clock; everything is on the rising edge
- rst_n  in  1  reset, asynchronous active-low
- smpl  in  WIDTH  signed two's-complement sample
- vld  in  1  smpl is valid this cycle; only vld cycles advance counters
- clr  in  1  synchronous clear of peak, counters, clip
- peak  out  WIDTH  unsigned held magnitude, registered
- bar  out  8  thermometer level of peak
- new_pk  out  1  one-cycle pulse, peak strictly increased
- clip  out  1  sticky full-scale flag

## Operation
- mag = |smpl| as WIDTH-bit unsigned; most-negative input maps to 2^(WIDTH-1) (no overflow).
- States: IDLE (peak==0), HOLD, DECAY. Reset/clr -> IDLE, peak=0, hold_cnt=0, dec_cnt=0, new_pk=0, clip=0.
- On vld with mag >= peak, mag != 0: peak<=mag, hold_cnt<=0, dec_cnt<=0, state<=HOLD; new_pk=1 only if mag > peak.
- On vld with mag < peak:
  - HOLD: hold_cnt++; when hold_cnt==HOLD-1 -> DECAY, dec_cnt<=0.
  - DECAY: dec_cnt++; when dec_cnt==DECAY_PER-1: peak <= (peak > DECAY_STEP) ? peak-DECAY_STEP : 0, dec_cnt<=0; if result is 0 -> IDLE.
- IDLE with vld and mag==0: no change.
- No vld: all state frozen.
- bar: level = peak >> (WIDTH-4) (range 0..8); bar[i] = (level > i). Combinational from peak register.
- clr and vld in same cycle: clr wins, sample discarded.
- Decay saturates at 0, never underflows; counters never exceed terminal counts.

## Timing
- Latency 1 cycle: vld sample at edge n reflected in peak/bar/new_pk after edge n+1.
- new_pk registered, high exactly one cycle per qualifying sample; back-to-back rising samples give consecutive pulses.
- clip set in the cycle after a qualifying sample, held until clr or rst_n.
- rst_n asserted mid-hold or mid-decay: immediate clear of all outputs, no partial decay step.
- Counter widths: $clog2(HOLD+1), $clog2(DECAY_PER+1).

## Configuration
- CLIP_DETECT_EN defined: clip sets on vld with smpl == 2^(WIDTH-1)-1 or smpl == -2^(WIDTH-1).
- Not defined: clip tied to 0, no clip register; port retained.

## Structure
- Package peak_meter_pkg: state enum typedef (IDLE, HOLD, DECAY), BAR_LEDS = 8 constant.
- One sub-module: abs_mag (combinational signed-to-magnitude, WIDTH parameter); comparator, counters and FSM stay in peak_meter.

## Test plan
Bench parameters: WIDTH=16, HOLD=4, DECAY_PER=2, DECAY_STEP=16'h1000, CLIP_DETECT_EN defined.
- Reset then idle -> peak=16'h0000, bar=8'h00, new_pk=0, clip=0.
- vld smpl=16'hC000 (-16384) -> next cycle peak=16'h4000, bar=8'h0F, new_pk one-cycle pulse, clip=0.
- From peak 16'h4000, 12 vld samples of 0 -> peak unchanged through 4th (enters DECAY), 16'h3000 after 6th, 16'h2000 after 8th, 16'h1000 after 10th, 16'h0000 after 12th, state IDLE, bar=8'h00.
- During DECAY at peak 16'h3000, vld smpl=16'h3000 -> peak stays 16'h3000, state HOLD, hold_cnt=0, new_pk=0.
- vld smpl=16'h8000 -> peak=16'h8000, bar=8'hFF, new_pk=1, clip=1 and stays 1 through later small samples.
- clr=1 with vld=1, smpl=16'h7FFF -> next cycle peak=0, clip=0, new_pk=0, state IDLE.
